// File: rtl/trainer_pkg.sv
// Shared types and board defaults for the logic trainer input front end.
package trainer_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL    = 2'b00,
        MODE_AUTO_RUN  = 2'b01,
        MODE_AUTO_HOLD = 2'b10
    } trainer_mode_t;

    // 2 ms debounce window and 1 s auto-run step at the 10 MHz board clock
    localparam int DEFAULT_DEBOUNCE_CYCLES = 20000;
    localparam int DEFAULT_AUTO_PERIOD     = 10000000;

endpackage

// File: rtl/trainer_debounce.sv
// Two-flop synchroniser, stability-count debouncer and rising-edge pulse for one raw input.
module trainer_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             rise_r;
    logic [CNT_W-1:0] cnt;

    // The edge pulse is registered together with the level so both rise on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            level  <= 1'b0;
            rise_r <= 1'b0;
            cnt    <= '0;
        end else if (ena) begin
            sync1  <= raw;
            sync2  <= sync1;
            rise_r <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level  <= sync2;
                rise_r <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = rise_r & ena;

endmodule

// File: rtl/trainer_input_conditioner.sv
// Produces gate operands a/b from debounced switches or from the auto truth-table sequencer.
module trainer_input_conditioner
    import trainer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int AUTO_PERIOD     = DEFAULT_AUTO_PERIOD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       sw_a_raw,
    input  logic       sw_b_raw,
    input  logic       btn_mode_raw,
    input  logic       btn_step_raw,
    output logic       a,
    output logic       b,
    output logic [1:0] mode,
    output logic       pattern_tick
);

    localparam int PER_W = $clog2(AUTO_PERIOD);
    localparam logic [PER_W-1:0] PER_MAX = PER_W'(AUTO_PERIOD - 1);

    logic sw_a, sw_b, mode_level, step_level;
    logic sw_a_rise_unused, sw_b_rise_unused, mode_rise, step_rise;

    trainer_mode_t    state;
    logic [1:0]       pattern;
    logic [1:0]       pattern_inc;
    logic [PER_W-1:0] period_cnt;
    logic             tick_r;

    trainer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .raw(sw_a_raw),
        .level(sw_a), .rise(sw_a_rise_unused)
    );
    trainer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .raw(sw_b_raw),
        .level(sw_b), .rise(sw_b_rise_unused)
    );
    trainer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_mode (
        .clk(clk), .rst_n(rst_n), .ena(ena), .raw(btn_mode_raw),
        .level(mode_level), .rise(mode_rise)
    );
    trainer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_step (
        .clk(clk), .rst_n(rst_n), .ena(ena), .raw(btn_step_raw),
        .level(step_level), .rise(step_rise)
    );

    assign pattern_inc = pattern + 2'd1;

    // a/b are loaded on the same edge as the pattern so the tick lines up with the visible change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= MODE_MANUAL;
            pattern    <= 2'b00;
            period_cnt <= '0;
            a          <= 1'b0;
            b          <= 1'b0;
            tick_r     <= 1'b0;
        end else if (ena) begin
            tick_r <= 1'b0;
            case (state)
                MODE_MANUAL: begin
                    if (mode_rise) begin
                        state      <= MODE_AUTO_RUN;
                        pattern    <= 2'b00;
                        period_cnt <= '0;
                        {a, b}     <= 2'b00;
                    end else begin
                        {a, b} <= {sw_a, sw_b};
                    end
                end
                MODE_AUTO_RUN: begin
                    if (mode_rise) begin
                        state      <= MODE_AUTO_HOLD;
                        period_cnt <= '0;
                        {a, b}     <= pattern;
                    end else if (period_cnt == PER_MAX) begin
                        period_cnt <= '0;
                        pattern    <= pattern_inc;
                        {a, b}     <= pattern_inc;
                        tick_r     <= 1'b1;
                    end else begin
                        period_cnt <= period_cnt + 1'b1;
                    end
                end
                MODE_AUTO_HOLD: begin
                    if (mode_rise) begin
                        state  <= MODE_MANUAL;
                        {a, b} <= {sw_a, sw_b};
                    end else if (step_rise) begin
                        pattern <= pattern_inc;
                        {a, b}  <= pattern_inc;
                        tick_r  <= 1'b1;
                    end
                end
                default: state <= MODE_MANUAL;
            endcase
        end
    end

    assign mode         = state;
    assign pattern_tick = tick_r & ena;

endmodule

// File: tb/tb_trainer_input_conditioner.sv
// Directed bench for trainer_input_conditioner with DEBOUNCE_CYCLES=4 and AUTO_PERIOD=8.
module tb_trainer_input_conditioner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       sw_a_raw = 1'b0;
    logic       sw_b_raw = 1'b0;
    logic       btn_mode_raw = 1'b0;
    logic       btn_step_raw = 1'b0;
    logic       a, b, pattern_tick;
    logic [1:0] mode;

    int tests_run = 0;
    int tests_failed = 0;

    trainer_input_conditioner #(.DEBOUNCE_CYCLES(4), .AUTO_PERIOD(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .sw_a_raw(sw_a_raw), .sw_b_raw(sw_b_raw),
        .btn_mode_raw(btn_mode_raw), .btn_step_raw(btn_step_raw),
        .a(a), .b(b), .mode(mode), .pattern_tick(pattern_tick)
    );

    always #5 clk = ~clk;

    // Drives raw buttons from the current negedge and returns just after the debounced level rises
    task automatic launch_press(input logic m, input logic s);
        btn_mode_raw = m;
        btn_step_raw = s;
        repeat (6) @(negedge clk);
    endtask

    task automatic release_buttons();
        btn_mode_raw = 1'b0;
        btn_step_raw = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({a, b} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_ab: got %b expected 00", {a, b}); end
        tests_run++;
        if (mode !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_mode: got %b expected 00", mode); end
        tests_run++;
        if (pattern_tick !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tick: got %b expected 0", pattern_tick); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_switch_latency();
        sw_a_raw = 1'b1;
        repeat (6) @(negedge clk);
        tests_run++;
        if (a !== 1'b0) begin tests_failed++; $display("[TB] FAIL sw_a_early: got %b expected 0", a); end
        @(negedge clk);
        tests_run++;
        if (a !== 1'b1) begin tests_failed++; $display("[TB] FAIL sw_a_latency: got %b expected 1", a); end
        tests_run++;
        if (b !== 1'b0) begin tests_failed++; $display("[TB] FAIL sw_a_b: got %b expected 0", b); end
        tests_run++;
        if (mode !== 2'b00) begin tests_failed++; $display("[TB] FAIL sw_a_mode: got %b expected 00", mode); end
        sw_a_raw = 1'b0;
        repeat (7) @(negedge clk);
        tests_run++;
        if (a !== 1'b0) begin tests_failed++; $display("[TB] FAIL sw_a_release: got %b expected 0", a); end
    endtask

    task automatic test_bounce();
        logic [13:0] seq;
        seq = 14'b11100100100100;
        for (int i = 13; i >= 0; i--) begin
            sw_b_raw = seq[i];
            @(negedge clk);
            tests_run++;
            if (b !== 1'b0) begin tests_failed++; $display("[TB] FAIL bounce_b[%0d]: got %b expected 0", i, b); end
        end
        sw_b_raw = 1'b0;
        repeat (8) @(negedge clk);
        tests_run++;
        if (b !== 1'b0) begin tests_failed++; $display("[TB] FAIL bounce_settle: got %b expected 0", b); end
    endtask

    task automatic test_auto_run();
        logic [1:0] expect_ab;
        launch_press(1'b1, 1'b0);
        tests_run++;
        if (mode !== 2'b00) begin tests_failed++; $display("[TB] FAIL run_mode_early: got %b expected 00", mode); end
        @(negedge clk);
        tests_run++;
        if (mode !== 2'b01) begin tests_failed++; $display("[TB] FAIL run_mode: got %b expected 01", mode); end
        tests_run++;
        if ({a, b} !== 2'b00 || pattern_tick !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL run_entry: got ab=%b tick=%b expected ab=00 tick=0", {a, b}, pattern_tick);
        end
        release_buttons();
        expect_ab = 2'b00;
        for (int step = 0; step < 4; step++) begin
            repeat (7) @(negedge clk);
            tests_run++;
            if ({a, b} !== expect_ab || pattern_tick !== 1'b0) begin
                tests_failed++; $display("[TB] FAIL run_hold%0d: got ab=%b tick=%b expected ab=%b tick=0", step, {a, b}, pattern_tick, expect_ab);
            end
            expect_ab = expect_ab + 2'd1;
            @(negedge clk);
            tests_run++;
            if ({a, b} !== expect_ab || pattern_tick !== 1'b1) begin
                tests_failed++; $display("[TB] FAIL run_step%0d: got ab=%b tick=%b expected ab=%b tick=1", step, {a, b}, pattern_tick, expect_ab);
            end
        end
    endtask

    task automatic test_auto_hold();
        repeat (11) @(negedge clk);
        launch_press(1'b1, 1'b0);
        tests_run++;
        if (mode !== 2'b01 || {a, b} !== 2'b10) begin
            tests_failed++; $display("[TB] FAIL hold_pre: got mode=%b ab=%b expected mode=01 ab=10", mode, {a, b});
        end
        @(negedge clk);
        tests_run++;
        if (mode !== 2'b10 || {a, b} !== 2'b10 || pattern_tick !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL hold_entry: got mode=%b ab=%b tick=%b expected 10 10 0", mode, {a, b}, pattern_tick);
        end
        release_buttons();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            tests_run++;
            if ({a, b} !== 2'b10 || pattern_tick !== 1'b0) begin
                tests_failed++; $display("[TB] FAIL hold_frozen%0d: got ab=%b tick=%b expected ab=10 tick=0", i, {a, b}, pattern_tick);
            end
        end
        launch_press(1'b0, 1'b1);
        @(negedge clk);
        tests_run++;
        if ({a, b} !== 2'b11 || pattern_tick !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL hold_step1: got ab=%b tick=%b expected ab=11 tick=1", {a, b}, pattern_tick);
        end
        release_buttons();
        @(negedge clk);
        tests_run++;
        if (pattern_tick !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_tick_width: got %b expected 0", pattern_tick); end
        repeat (8) @(negedge clk);
        launch_press(1'b0, 1'b1);
        @(negedge clk);
        tests_run++;
        if ({a, b} !== 2'b00 || pattern_tick !== 1'b1 || mode !== 2'b10) begin
            tests_failed++; $display("[TB] FAIL hold_step2: got ab=%b tick=%b mode=%b expected 00 1 10", {a, b}, pattern_tick, mode);
        end
        release_buttons();
        repeat (8) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        launch_press(1'b1, 1'b1);
        @(negedge clk);
        tests_run++;
        if (mode !== 2'b00 || pattern_tick !== 1'b0 || {a, b} !== 2'b00) begin
            tests_failed++; $display("[TB] FAIL simul: got mode=%b tick=%b ab=%b expected 00 0 00", mode, pattern_tick, {a, b});
        end
        release_buttons();
        repeat (8) @(negedge clk);
        launch_press(1'b0, 1'b1);
        @(negedge clk);
        tests_run++;
        if (mode !== 2'b00 || pattern_tick !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL manual_step: got mode=%b tick=%b expected 00 0", mode, pattern_tick);
        end
        release_buttons();
        repeat (8) @(negedge clk);
    endtask

    task automatic test_ena_and_reset();
        launch_press(1'b1, 1'b0);
        @(negedge clk);
        tests_run++;
        if (mode !== 2'b01) begin tests_failed++; $display("[TB] FAIL ena_entry: got %b expected 01", mode); end
        release_buttons();
        repeat (3) @(negedge clk);
        ena = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests_run++;
            if ({a, b} !== 2'b00 || mode !== 2'b01 || pattern_tick !== 1'b0) begin
                tests_failed++; $display("[TB] FAIL ena_frozen%0d: got ab=%b mode=%b tick=%b expected 00 01 0", i, {a, b}, mode, pattern_tick);
            end
        end
        ena = 1'b1;
        repeat (4) @(negedge clk);
        tests_run++;
        if ({a, b} !== 2'b00 || pattern_tick !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL ena_resume_early: got ab=%b tick=%b expected 00 0", {a, b}, pattern_tick);
        end
        @(negedge clk);
        tests_run++;
        if ({a, b} !== 2'b01 || pattern_tick !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL ena_resume_step: got ab=%b tick=%b expected 01 1", {a, b}, pattern_tick);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (mode !== 2'b00 || a !== 1'b0 || b !== 1'b0 || pattern_tick !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL async_reset: got mode=%b a=%b b=%b tick=%b expected 00 0 0 0", mode, a, b, pattern_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_switch_latency();
        test_bounce();
        test_auto_run();
        test_auto_hold();
        test_simultaneous();
        test_ena_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
